// File: rtl/esc_pwm_driver_if.sv
//==============================================================================
// Module      : esc_pwm_driver_if
// Description : Rate/arm inputs and ESC pulse/status outputs of esc_pwm_driver.
// Revision    : 1.0 - initial release
//==============================================================================
`default_nettype none

interface esc_pwm_driver_if #(
   parameter int RATE_BIT_WIDTH = 8
);
   logic [RATE_BIT_WIDTH-1:0] motor_1_rate;
   logic [RATE_BIT_WIDTH-1:0] motor_2_rate;
   logic [RATE_BIT_WIDTH-1:0] motor_3_rate;
   logic [RATE_BIT_WIDTH-1:0] motor_4_rate;
   logic                      rate_valid;
   logic                      arm;
   logic                      pwm_1;
   logic                      pwm_2;
   logic                      pwm_3;
   logic                      pwm_4;
   logic                      armed;
   logic                      frame_start;
   logic                      failsafe;

   modport master (
      output motor_1_rate, motor_2_rate, motor_3_rate, motor_4_rate, rate_valid, arm,
      input  pwm_1, pwm_2, pwm_3, pwm_4, armed, frame_start, failsafe
   );

   modport slave (
      input  motor_1_rate, motor_2_rate, motor_3_rate, motor_4_rate, rate_valid, arm,
      output pwm_1, pwm_2, pwm_3, pwm_4, armed, frame_start, failsafe
   );
endinterface

`default_nettype wire

// File: rtl/esc_pwm_driver.sv
//==============================================================================
// Module      : esc_pwm_driver
// Description : Four-channel ESC servo PWM with arming sequence and
//               frame-synchronous double-buffered rates.
//               Optional rate timeout: define ESC_FAILSAFE_EN.
// Revision    : 1.0 - initial release
//==============================================================================
`default_nettype none

module esc_pwm_driver #(
   parameter int RATE_BIT_WIDTH  = 8,
   parameter int SYS_CLK_HZ      = 38_000_000,
   parameter int FRAME_HZ        = 50,
   parameter int MIN_PULSE_US    = 1000,
   parameter int MAX_PULSE_US    = 2000,
   parameter int ARM_FRAMES      = 100,
   parameter int FAILSAFE_FRAMES = 25
) (
   input  logic               sys_clk,
   input  logic               rst_n,
   esc_pwm_driver_if.slave    bus
);

   localparam int     c_FRAME_TICKS = SYS_CLK_HZ / FRAME_HZ;
   localparam longint c_MIN_L       = (longint'(MIN_PULSE_US) * longint'(SYS_CLK_HZ)) / longint'(1_000_000);
   localparam longint c_MAX_L       = (longint'(MAX_PULSE_US) * longint'(SYS_CLK_HZ)) / longint'(1_000_000);
   localparam int     c_MIN_TICKS   = int'(c_MIN_L);
   localparam int     c_SPAN_TICKS  = int'(c_MAX_L - c_MIN_L);
   localparam int     c_CNT_W       = $clog2(c_FRAME_TICKS);
   localparam int     c_SPAN_W      = $clog2(c_SPAN_TICKS + 1);
   localparam int     c_PROD_W      = RATE_BIT_WIDTH + c_SPAN_W;
   localparam int     c_ARM_W       = (ARM_FRAMES > 1) ? $clog2(ARM_FRAMES) : 1;

   localparam logic [c_CNT_W-1:0]  c_LAST_CNT = c_CNT_W'(c_FRAME_TICKS - 1);
   localparam logic [c_CNT_W-1:0]  c_MIN_W    = c_CNT_W'(c_MIN_TICKS);
   localparam logic [c_PROD_W-1:0] c_SPAN_P   = c_PROD_W'(c_SPAN_TICKS);
   localparam logic [c_ARM_W-1:0]  c_ARM_LAST = c_ARM_W'(ARM_FRAMES - 1);

   typedef enum logic [1:0] {
      ST_DISARMED = 2'd0,
      ST_ARMING   = 2'd1,
      ST_ARMED    = 2'd2
   } state_t;

   state_t                     r_state;
   state_t                     w_state_next;
   logic [c_ARM_W-1:0]         r_arm_cnt;
   logic [c_ARM_W-1:0]         w_arm_cnt_next;
   logic [c_CNT_W-1:0]         r_frame_cnt;
   logic                       w_boundary;
   logic                       r_frame_start;
   logic                       w_fs_block;
   logic                       w_load_armed;
   logic [RATE_BIT_WIDTH-1:0]  w_rate   [4];
   logic [RATE_BIT_WIDTH-1:0]  r_shadow [4];
   logic [c_CNT_W-1:0]         r_active [4];
   logic [c_CNT_W-1:0]         w_scaled [4];
   logic [3:0]                 r_pwm;

   assign w_rate[0] = bus.motor_1_rate;
   assign w_rate[1] = bus.motor_2_rate;
   assign w_rate[2] = bus.motor_3_rate;
   assign w_rate[3] = bus.motor_4_rate;

   assign w_boundary = (r_frame_cnt == c_LAST_CNT);

   always_ff @(posedge sys_clk or negedge rst_n) begin
      if (!rst_n) begin
         r_frame_cnt   <= '0;
         r_frame_start <= 1'b0;
      end else begin
         r_frame_cnt   <= w_boundary ? '0 : r_frame_cnt + c_CNT_W'(1);
         r_frame_start <= w_boundary;
      end
   end

   always_ff @(posedge sys_clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state   <= ST_DISARMED;
         r_arm_cnt <= '0;
      end else begin
         r_state   <= w_state_next;
         r_arm_cnt <= w_arm_cnt_next;
      end
   end

   // Arm level is honoured every cycle; progress toward ARMED only at boundaries.
   always_comb begin
      w_state_next   = r_state;
      w_arm_cnt_next = r_arm_cnt;
      case (r_state)
         ST_DISARMED: begin
            if (w_boundary && bus.arm) begin
               w_state_next   = ST_ARMING;
               w_arm_cnt_next = '0;
            end
         end
         ST_ARMING: begin
            if (!bus.arm) begin
               w_state_next = ST_DISARMED;
            end else if (w_boundary) begin
               if (r_arm_cnt == c_ARM_LAST) begin
                  w_state_next = ST_ARMED;
               end else begin
                  w_arm_cnt_next = r_arm_cnt + c_ARM_W'(1);
               end
            end
         end
         ST_ARMED: begin
            if (!bus.arm) begin
               w_state_next = ST_DISARMED;
            end
         end
         default: begin
            w_state_next = ST_DISARMED;
         end
      endcase
   end

`ifdef ESC_FAILSAFE_EN
   localparam int                c_FS_W    = (FAILSAFE_FRAMES > 1) ? $clog2(FAILSAFE_FRAMES) : 1;
   localparam logic [c_FS_W-1:0] c_FS_LAST = c_FS_W'(FAILSAFE_FRAMES - 1);

   logic              r_seen;
   logic [c_FS_W-1:0] r_fs_cnt;
   logic [c_FS_W-1:0] w_fs_cnt_next;
   logic              r_failsafe;
   logic              w_failsafe_next;

   // Counts ARMED boundaries that closed a frame without any rate strobe.
   always_comb begin
      w_fs_cnt_next   = r_fs_cnt;
      w_failsafe_next = r_failsafe;
      if (w_state_next != ST_ARMED || bus.rate_valid) begin
         w_fs_cnt_next   = '0;
         w_failsafe_next = 1'b0;
      end else if (w_boundary && r_state == ST_ARMED && !r_seen) begin
         if (r_fs_cnt == c_FS_LAST) begin
            w_failsafe_next = 1'b1;
         end else begin
            w_fs_cnt_next = r_fs_cnt + c_FS_W'(1);
         end
      end
   end

   always_ff @(posedge sys_clk or negedge rst_n) begin
      if (!rst_n) begin
         r_seen     <= 1'b0;
         r_fs_cnt   <= '0;
         r_failsafe <= 1'b0;
      end else begin
         r_seen     <= w_boundary ? 1'b0 : (r_seen | bus.rate_valid);
         r_fs_cnt   <= w_fs_cnt_next;
         r_failsafe <= w_failsafe_next;
      end
   end

   assign w_fs_block   = w_failsafe_next;
   assign bus.failsafe = r_failsafe;
`else
   assign w_fs_block   = 1'b0;
   assign bus.failsafe = 1'b0;
`endif

   // Width for the coming frame depends on the state it will run in.
   assign w_load_armed = (w_state_next == ST_ARMED) && !w_fs_block;

   generate
      for (genvar gi = 0; gi < 4; gi++) begin : g_motor
         logic [c_PROD_W-1:0] w_prod;
         assign w_prod       = c_PROD_W'(r_shadow[gi]) * c_SPAN_P;
         assign w_scaled[gi] = c_CNT_W'(w_prod >> RATE_BIT_WIDTH);
      end
   endgenerate

   always_ff @(posedge sys_clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int i = 0; i < 4; i++) begin
            r_shadow[i] <= '0;
            r_active[i] <= c_MIN_W;
         end
         r_pwm <= '0;
      end else begin
         for (int i = 0; i < 4; i++) begin
            if (bus.rate_valid) begin
               r_shadow[i] <= w_rate[i];
            end
            if (w_boundary) begin
               r_active[i] <= w_load_armed ? (c_MIN_W + w_scaled[i]) : c_MIN_W;
            end
            r_pwm[i] <= (r_frame_cnt < r_active[i]);
         end
      end
   end

   assign bus.pwm_1       = r_pwm[0];
   assign bus.pwm_2       = r_pwm[1];
   assign bus.pwm_3       = r_pwm[2];
   assign bus.pwm_4       = r_pwm[3];
   assign bus.armed       = (r_state == ST_ARMED);
   assign bus.frame_start = r_frame_start;

endmodule

`default_nettype wire

// File: tb/tb_esc_pwm_driver.sv
//==============================================================================
// Module      : tb_esc_pwm_driver
// Description : Self-checking bench for esc_pwm_driver (1 MHz clock, 4000-tick frames).
// Revision    : 1.0 - initial release
//==============================================================================
`default_nettype none

module tb_esc_pwm_driver;

   localparam int FT       = 4000;
   localparam int MIN      = 1000;
   localparam int SPAN     = 1000;
   localparam int ARM      = 2;
   localparam int FSF      = 3;
   localparam int NFRAMES  = 24;
`ifdef ESC_FAILSAFE_EN
   localparam bit FS_EN = 1'b1;
`else
   localparam bit FS_EN = 1'b0;
`endif

   logic sys_clk;
   logic rst_n;

   esc_pwm_driver_if #(.RATE_BIT_WIDTH(8)) bus ();

   esc_pwm_driver #(
      .RATE_BIT_WIDTH (8),
      .SYS_CLK_HZ     (1_000_000),
      .FRAME_HZ       (250),
      .MIN_PULSE_US   (1000),
      .MAX_PULSE_US   (2000),
      .ARM_FRAMES     (ARM),
      .FAILSAFE_FRAMES(FSF)
   ) dut (
      .sys_clk (sys_clk),
      .rst_n   (rst_n),
      .bus     (bus.slave)
   );

   int checks = 0;
   int errors = 0;
   int cyc    = 0;
   bit run    = 1'b0;

   int exp_w   [0:NFRAMES-1][0:3];
   int dir_exp [0:NFRAMES-1][0:3];

   task automatic chk(input string name, input int act, input int exp);
      checks++;
      if (act != exp) begin
         errors++;
         $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   initial begin
      sys_clk = 1'b0;
      forever #5 sys_clk = ~sys_clk;
   end

   initial begin
      forever begin
         @(posedge sys_clk);
         if (run) cyc <= cyc + 1;
      end
   end

   initial begin
      #(120_000 * 10);
      $display("FAIL watchdog: got timeout expected completion");
      $fatal(1, "watchdog");
   end

   // Frame-level reference: widths from the shadow held at each boundary, arming
   // from how long arm has been continuously high, failsafe from strobe-less boundaries.
   int  k, f;
   int  pw [4];
   int  rd [4];
   int  hi [4];
   int  shadow [4];
   int  run_len = 0;
   int  fs_cnt  = 0;
   bit  seen    = 1'b0;
   bit  fs      = 1'b0;
   bit  aa;
   bit  exp_armed = 1'b0;
   bit  exp_fs    = 1'b0;
   bit  prev_arm  = 1'b0;
   bit  arm_chg   = 1'b0;

   initial begin
      for (int i = 0; i < 4; i++) begin
         hi[i] = 0;
         shadow[i] = 0;
      end
      forever begin
         @(negedge sys_clk);
         if (run) begin
            k = cyc;
            pw = '{int'(bus.pwm_1), int'(bus.pwm_2), int'(bus.pwm_3), int'(bus.pwm_4)};
            rd = '{int'(bus.motor_1_rate), int'(bus.motor_2_rate),
                   int'(bus.motor_3_rate), int'(bus.motor_4_rate)};
            if (k == 0) begin
               for (int m = 0; m < 4; m++) chk($sformatf("first cycle pwm_%0d", m + 1), pw[m], 0);
            end else begin
               for (int m = 0; m < 4; m++) if (pw[m] != 0) hi[m]++;
               if (k % FT == 0) begin
                  f = (k - 1) / FT;
                  for (int m = 0; m < 4; m++) begin
                     chk($sformatf("width f%0d pwm_%0d", f, m + 1), hi[m], exp_w[f][m]);
                     if (dir_exp[f][m] >= 0)
                        chk($sformatf("directed width f%0d pwm_%0d", f, m + 1), hi[m], dir_exp[f][m]);
                     hi[m] = 0;
                  end
                  chk("frame_start high", int'(bus.frame_start), 1);
               end
               if (k % FT == 1) chk("frame_start low", int'(bus.frame_start), 0);
            end
            if (k % 97 == 0 || arm_chg) chk("armed", int'(bus.armed), int'(exp_armed));
            if (k % 97 == 0) chk("failsafe", int'(bus.failsafe), int'(exp_fs));

            run_len = bus.arm ? run_len + 1 : 0;
            aa = (run_len >= ((k + 1) % FT) + ARM * FT + 1);
            if (k % FT == FT - 1) begin
               seen = seen | bus.rate_valid;
               if (FS_EN && exp_armed && aa) fs_cnt = seen ? 0 : fs_cnt + 1;
               else fs_cnt = 0;
               seen = 1'b0;
               fs = (fs_cnt >= FSF);
               for (int m = 0; m < 4; m++)
                  exp_w[(k + 1) / FT][m] = (aa && !fs) ? MIN + (shadow[m] * SPAN) / 256 : MIN;
               if (bus.rate_valid) shadow = rd;
            end else begin
               if (bus.rate_valid) begin
                  shadow = rd;
                  seen   = 1'b1;
                  fs_cnt = 0;
                  fs     = 1'b0;
               end
               if (!aa) begin
                  fs_cnt = 0;
                  fs     = 1'b0;
               end
            end
            exp_armed = aa;
            exp_fs    = FS_EN && fs;
            arm_chg   = (bus.arm != prev_arm);
            prev_arm  = bus.arm;
         end
      end
   end

   task automatic goto(input int c);
      if (c < cyc) begin
         errors++;
         checks++;
         $display("FAIL schedule: got cycle %0d expected at most %0d", cyc, c);
      end
      while (cyc < c) begin
         @(posedge sys_clk);
         #1;
      end
   endtask

   task automatic junk_rates();
      bus.motor_1_rate = 8'($urandom);
      bus.motor_2_rate = 8'($urandom);
      bus.motor_3_rate = 8'($urandom);
      bus.motor_4_rate = 8'($urandom);
   endtask

   task automatic strobe(input int c, input int a, input int b, input int d, input int e);
      goto(c);
      bus.motor_1_rate = 8'(a);
      bus.motor_2_rate = 8'(b);
      bus.motor_3_rate = 8'(d);
      bus.motor_4_rate = 8'(e);
      bus.rate_valid   = 1'b1;
      goto(c + 1);
      bus.rate_valid   = 1'b0;
      junk_rates();
   endtask

   task automatic set_dir(input int fr, input int a, input int b, input int d, input int e);
      dir_exp[fr][0] = a;
      dir_exp[fr][1] = b;
      dir_exp[fr][2] = d;
      dir_exp[fr][3] = e;
   endtask

   typedef struct {
      int frame; int cnt; bit arm; bit valid;
      int r1; int r2; int r3; int r4;
      int chk_frame; int w1; int w2; int w3; int w4;
   } vec_t;

   vec_t tbl [9];

   initial begin
      tbl[0] = '{0,   10, 1'b0, 1'b1, 200, 200, 200, 200, 0, 1000, 1000, 1000, 1000};
      tbl[1] = '{1,   10, 1'b0, 1'b0,   0,   0,   0,   0, 1, 1000, 1000, 1000, 1000};
      tbl[2] = '{2,   10, 1'b1, 1'b1,   0, 128, 255,  64, 2, 1000, 1000, 1000, 1000};
      tbl[3] = '{3,   10, 1'b1, 1'b0,   0,   0,   0,   0, 3, 1000, 1000, 1000, 1000};
      tbl[4] = '{4,   10, 1'b1, 1'b0,   0,   0,   0,   0, 4, 1000, 1000, 1000, 1000};
      tbl[5] = '{5,   10, 1'b1, 1'b0,   0,   0,   0,   0, 5, 1000, 1500, 1996, 1250};
      tbl[6] = '{6, 1200, 1'b1, 1'b1,   0, 255, 128,  64, 6, 1000, 1500, 1996, 1250};
      tbl[7] = '{7, 3999, 1'b1, 1'b1,   0, 255,   0,  64, 7, 1000, 1996, 1500, 1250};
      tbl[8] = '{8,   10, 1'b1, 1'b0,   0,   0,   0,   0, 8, 1000, 1996, 1500, 1250};

      for (int i = 0; i < NFRAMES; i++)
         for (int m = 0; m < 4; m++) begin
            exp_w[i][m]   = MIN;
            dir_exp[i][m] = -1;
         end

      rst_n          = 1'b0;
      bus.arm        = 1'b0;
      bus.rate_valid = 1'b0;
      junk_rates();
      repeat (3) @(posedge sys_clk);
      @(negedge sys_clk);
      chk("reset pwm_1", int'(bus.pwm_1), 0);
      chk("reset pwm_2", int'(bus.pwm_2), 0);
      chk("reset pwm_3", int'(bus.pwm_3), 0);
      chk("reset pwm_4", int'(bus.pwm_4), 0);
      chk("reset armed", int'(bus.armed), 0);
      chk("reset frame_start", int'(bus.frame_start), 0);
      chk("reset failsafe", int'(bus.failsafe), 0);
      @(posedge sys_clk);
      #1;
      rst_n = 1'b1;
      cyc   = 0;
      run   = 1'b1;

      for (int i = 0; i < 9; i++) begin
         set_dir(tbl[i].chk_frame, tbl[i].w1, tbl[i].w2, tbl[i].w3, tbl[i].w4);
         goto(tbl[i].frame * FT + tbl[i].cnt);
         bus.arm = tbl[i].arm;
         if (tbl[i].valid) strobe(cyc, tbl[i].r1, tbl[i].r2, tbl[i].r3, tbl[i].r4);
      end

      // Disarm in the middle of the 1996-tick pulse on pwm_2.
      set_dir(9, 1000, 1996, 1000, 1250);
      set_dir(10, 1000, 1000, 1000, 1000);
      goto(9 * FT + 500);
      bus.arm = 1'b0;
      @(negedge sys_clk);
      chk("armed before disarm takes effect", int'(bus.armed), 1);
      @(posedge sys_clk);
      #1;
      @(negedge sys_clk);
      chk("armed after disarm", int'(bus.armed), 0);
      chk("pwm_2 continues after disarm", int'(bus.pwm_2), 1);

      // Re-arm with one strobe, then let strobes lapse.
      goto(10 * FT + 10);
      bus.arm = 1'b1;
      strobe(cyc, 128, 128, 128, 128);
      set_dir(13, 1500, 1500, 1500, 1500);
      set_dir(14, 1500, 1500, 1500, 1500);
      set_dir(15, 1500, 1500, 1500, 1500);
      if (FS_EN) set_dir(16, 1000, 1000, 1000, 1000);
      else set_dir(16, 1500, 1500, 1500, 1500);
      set_dir(17, 1500, 1500, 1500, 1500);
      goto(16 * FT + 100);
      @(negedge sys_clk);
      chk("failsafe after strobe timeout", int'(bus.failsafe), int'(FS_EN));
      strobe(16 * FT + 2000, 128, 128, 128, 128);
      @(negedge sys_clk);
      chk("failsafe cleared by strobe", int'(bus.failsafe), 0);

      for (int fr = 18; fr < 22; fr++) begin
         int c1, c2;
         c1 = fr * FT + $urandom_range(5, 1900);
         c2 = fr * FT + $urandom_range(2000, 3990);
         strobe(c1, $urandom_range(0, 255), $urandom_range(0, 255),
                $urandom_range(0, 255), $urandom_range(0, 255));
         if ($urandom_range(0, 2) == 0) begin
            goto(c1 + 50);
            bus.arm = 1'b0;
            goto(c1 + 51);
            bus.arm = 1'b1;
         end
         strobe(c2, $urandom_range(0, 255), $urandom_range(0, 255),
                $urandom_range(0, 255), $urandom_range(0, 255));
      end

      // Asynchronous reset while pulses are high.
      goto(22 * FT + 300);
      chk("pwm_1 high before async reset", int'(bus.pwm_1), 1);
      #2;
      run   = 1'b0;
      rst_n = 1'b0;
      #1;
      chk("async reset pwm_1", int'(bus.pwm_1), 0);
      chk("async reset pwm_2", int'(bus.pwm_2), 0);
      chk("async reset pwm_3", int'(bus.pwm_3), 0);
      chk("async reset pwm_4", int'(bus.pwm_4), 0);
      chk("async reset armed", int'(bus.armed), 0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

`default_nettype wire
